// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, op classes, funct values and issue FSM states
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_t;

  typedef logic [1:0] op_class_t;

  localparam op_class_t CLASS_MEM   = 2'b00;
  localparam op_class_t CLASS_BEQ   = 2'b01;
  localparam op_class_t CLASS_RTYPE = 2'b10;
  localparam op_class_t CLASS_ILL   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational op class / funct to ALU op code decoder
import alu_pkg::*;

module alu_op_decode (
  input  logic [1:0] op_class,
  input  logic [5:0] funct,
  output logic [3:0] op,
  output logic       illegal
);

  always_comb begin
    op      = ALU_ADD;
    illegal = 1'b0;
    case (op_class)
      CLASS_MEM: op = ALU_ADD;
      CLASS_BEQ: op = ALU_SUB;
      CLASS_RTYPE: begin
        case (funct)
          FUNCT_ADD: op = ALU_ADD;
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_AND: op = ALU_AND;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_SLT: op = ALU_SLT;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues decoded requests to a fixed-latency ALU and returns responses
import alu_pkg::*;

module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_class,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic             rsp_err,
  output logic [15:0]      op_count
);

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             beq_q, beq_d;
  logic             req_ready_d, rsp_valid_d;
  logic [3:0]       alu_op_d;
  logic [WIDTH-1:0] alu_a_d, alu_b_d, rsp_result_d;
  logic             rsp_zero_d, rsp_taken_d, rsp_err_d;
  logic [15:0]      op_count_d;
  logic [3:0]       dec_op;
  logic             dec_illegal;

  alu_op_decode u_decode (
    .op_class (req_class),
    .funct    (req_funct),
    .op       (dec_op),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      beq_q      <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_taken  <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beq_q      <= beq_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      alu_op     <= alu_op_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      rsp_result <= rsp_result_d;
      rsp_zero   <= rsp_zero_d;
      rsp_taken  <= rsp_taken_d;
      rsp_err    <= rsp_err_d;
      op_count   <= op_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beq_d        = beq_q;
    alu_op_d     = alu_op;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    rsp_result_d = rsp_result;
    rsp_zero_d   = rsp_zero;
    rsp_taken_d  = rsp_taken;
    rsp_err_d    = rsp_err;
    op_count_d   = op_count;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (dec_illegal) begin
            // Illegal requests skip the ALU and leave its port bundle untouched
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_taken_d  = 1'b0;
            state_d      = ST_RESP;
          end else begin
            alu_op_d = dec_op;
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            cnt_d    = LAT_INIT;
            beq_d    = (req_class == CLASS_BEQ);
            state_d  = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_taken_d  = beq_q & alu_zero;
          rsp_err_d    = 1'b0;
          if (op_count != 16'hFFFF) op_count_d = op_count + 16'd1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid && rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl at ALU_LAT 1 and 4
module tb_alu_issue_ctrl;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        taken;
    logic        err;
    logic [3:0]  op;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst = 2'b11;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  rsp_ready = 2'b00;
  logic [1:0]  req_ready, rsp_valid, rsp_zero, rsp_taken, rsp_err;
  logic [1:0]  req_class = 2'b00;
  logic [5:0]  req_funct = 6'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [31:0] alu_a [2];
  logic [31:0] alu_b [2];
  logic [31:0] alu_result [2];
  logic [31:0] rsp_result [2];
  logic [3:0]  alu_op [2];
  logic [15:0] op_count [2];
  logic        alu_zero [2];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_class(req_class), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_result(alu_result[0]), .alu_zero(alu_zero[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_zero(rsp_zero[0]), .rsp_taken(rsp_taken[0]), .rsp_err(rsp_err[0]),
    .op_count(op_count[0])
  );

  alu_issue_ctrl #(.WIDTH(32), .ALU_LAT(4)) dut4 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_class(req_class), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_result(alu_result[1]), .alu_zero(alu_zero[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_zero(rsp_zero[1]), .rsp_taken(rsp_taken[1]), .rsp_err(rsp_err[1]),
    .op_count(op_count[1])
  );

  // Behavioural ALU keyed on the op code the controller drives
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return {31'b0, (a < b)};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign alu_result[g] = alu_fn(alu_op[g], alu_a[g], alu_b[g]);
    assign alu_zero[g]   = (alu_result[g] == 32'b0);
  end

  // Expected response derived straight from class/funct, independent of the DUT's op code
  function automatic exp_t model(input logic [1:0] c, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.err = 1'b0; e.op = 4'b0010; e.result = 32'b0;
    case (c)
      2'b00: begin e.op = 4'b0010; e.result = a + b; end
      2'b01: begin e.op = 4'b0110; e.result = a - b; end
      2'b10: begin
        case (f)
          6'b100000: begin e.op = 4'b0010; e.result = a + b; end
          6'b100010: begin e.op = 4'b0110; e.result = a - b; end
          6'b100100: begin e.op = 4'b0000; e.result = a & b; end
          6'b100101: begin e.op = 4'b0001; e.result = a | b; end
          6'b101010: begin e.op = 4'b0111; e.result = (a < b) ? 32'd1 : 32'd0; end
          default:   e.err = 1'b1;
        endcase
      end
      default: e.err = 1'b1;
    endcase
    if (e.err) e.result = 32'b0;
    e.zero  = !e.err && (e.result == 32'b0);
    e.taken = (c == 2'b01) && e.zero;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic do_op(input int d, input int lat, input logic [1:0] c, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input int stall);
    exp_t        e;
    int          n;
    logic [3:0]  op_before;
    logic [15:0] cnt_before;
    sb.push_back(model(c, f, a, b));
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      check("req_ready_timeout", 32'(req_ready[d]), 32'd1);
      void'(sb.pop_front());
      return;
    end
    op_before  = alu_op[d];
    cnt_before = op_count[d];
    req_class = c; req_funct = f; req_a = a; req_b = b;
    req_valid[d] = 1'b1;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[d] && n < 40);
    e = sb.pop_front();
    check("latency", n, e.err ? 1 : lat + 1);
    check("rsp_result", rsp_result[d], e.result);
    check("rsp_zero", 32'(rsp_zero[d]), 32'(e.zero));
    check("rsp_taken", 32'(rsp_taken[d]), 32'(e.taken));
    check("rsp_err", 32'(rsp_err[d]), 32'(e.err));
    check("alu_op", 32'(alu_op[d]), e.err ? 32'(op_before) : 32'(e.op));
    check("op_count", 32'(op_count[d]), e.err ? 32'(cnt_before) : 32'(cnt_before + 16'd1));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid[d]), 32'd1);
      check("stall_rsp_result", rsp_result[d], e.result);
      check("stall_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("post_req_ready", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic check_reset_vals(input int d);
    check("rst_req_ready", 32'(req_ready[d]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("rst_alu_op", 32'(alu_op[d]), 32'd0);
    check("rst_alu_a", alu_a[d], 32'd0);
    check("rst_alu_b", alu_b[d], 32'd0);
    check("rst_rsp_result", rsp_result[d], 32'd0);
    check("rst_rsp_flags", {29'b0, rsp_zero[d], rsp_taken[d], rsp_err[d]}, 32'd0);
    check("rst_op_count", 32'(op_count[d]), 32'd0);
  endtask

  logic [5:0] functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic saw;
    repeat (3) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rst = 2'b00;
    @(negedge clk);
    check("req_ready_after_rst0", 32'(req_ready[0]), 32'd1);
    check("req_ready_after_rst1", 32'(req_ready[1]), 32'd1);

    do_op(0, 1, 2'b10, 6'b100000, 32'd5, 32'd7, 0);
    do_op(0, 1, 2'b01, 6'b000000, 32'h1234, 32'h1234, 0);
    do_op(0, 1, 2'b01, 6'b000000, 32'd3, 32'd4, 0);
    do_op(0, 1, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(0, 1, 2'b10, 6'b101010, 32'd1, 32'd2, 0);
    do_op(0, 1, 2'b10, 6'b000111, 32'd9, 32'd9, 0);
    do_op(0, 1, 2'b11, 6'b100000, 32'd1, 32'd1, 0);
    do_op(0, 1, 2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_0FF0, 5);
    do_op(0, 1, 2'b00, 6'b111111, 32'h8000_0000, 32'h8000_0000, 0);
    for (int i = 0; i < 6; i++)
      do_op(0, 1, 2'b10, functs[$urandom_range(0, 4)], $urandom, $urandom, $urandom_range(0, 2));

    // Reset dut4 two cycles into a 4-cycle EXEC
    req_class = 2'b00; req_funct = 6'b0; req_a = 32'd10; req_b = 32'd20;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    check_reset_vals(1);
    rst[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1]) saw = 1'b1;
    end
    rsp_ready[1] = 1'b0;
    check("no_rsp_after_rst", 32'(saw), 32'd0);
    do_op(1, 4, 2'b10, 6'b100101, 32'h00FF_0000, 32'h0000_00FF, 1);
    do_op(1, 4, 2'b01, 6'b000000, 32'd77, 32'd77, 0);

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
